// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared encodings for the Y86-64 Execute stage: instruction
//                codes, ALU function codes, jump/move condition codes,
//                condition-code bit positions and the condition evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

   // Instruction codes (icode field)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // ALU function codes (low bits of ifun for OPq)
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   // Condition codes (ifun for jXX / cmovXX)
   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   // Bit positions inside the {ZF,SF,OF} condition-code vector
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // Evaluate a jump/move condition against a {ZF,SF,OF} snapshot.
   // Codes above C_G evaluate to 0; the caller flags them as illegal.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [2:0] flags);
      logic w_zf;
      logic w_lt;
      w_zf = flags[CC_ZF];
      w_lt = flags[CC_SF] ^ flags[CC_OF];
      case (cond)
         C_ALWAYS: cond_eval = 1'b1;
         C_LE:     cond_eval = w_lt | w_zf;
         C_L:      cond_eval = w_lt;
         C_E:      cond_eval = w_zf;
         C_NE:     cond_eval = ~w_zf;
         C_GE:     cond_eval = ~w_lt;
         C_G:      cond_eval = ~w_lt & ~w_zf;
         default:  cond_eval = 1'b0;
      endcase
   endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_alu.sv
`default_nettype none
// ============================================================================
//  Module      : y86_alu
//  Description : Combinational word-wide Y86-64 ALU (add, sub, and, xor) with
//                zero, sign and signed-overflow flag generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_alu
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] aluA,
   input  logic [WIDTH-1:0] aluB,
   input  logic [1:0]       alufun,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam int c_MSB = WIDTH - 1;

   // Operation select and signed-overflow detection; sub computes B - A
   always_comb begin
      result = '0;
      of     = 1'b0;
      case (alufun)
         ALU_ADD: begin
            result = aluB + aluA;
            of     = (aluA[c_MSB] == aluB[c_MSB]) && (result[c_MSB] != aluA[c_MSB]);
         end
         ALU_SUB: begin
            result = aluB - aluA;
            of     = (aluA[c_MSB] != aluB[c_MSB]) && (result[c_MSB] != aluB[c_MSB]);
         end
         ALU_AND: result = aluB & aluA;
         ALU_XOR: result = aluB ^ aluA;
         default: result = '0;
      endcase
   end

   assign zf = (result == '0);
   assign sf = result[c_MSB];

endmodule : y86_alu
`default_nettype wire

// File: rtl/y86_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : y86_execute_stage
//  Description : Registered Y86-64 SEQ Execute stage. Selects ALU operands,
//                computes valE, owns the {ZF,SF,OF} condition codes,
//                evaluates Cnd and presents results through a one-entry
//                valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_execute_stage
   import y86_pkg::*;
#(
   parameter int         WIDTH    = 64,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic [WIDTH-1:0] valC,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_icode,
   output logic [WIDTH-1:0] out_valE,
   output logic [WIDTH-1:0] out_valA,
   output logic             out_cnd,
   output logic             out_err,
   output logic [2:0]       cc
);

   // Stack-pointer adjustments: ~7 is -8 in two's complement at any width
   localparam logic [WIDTH-1:0] c_NEG8 = ~(WIDTH'(7));
   localparam logic [WIDTH-1:0] c_POS8 = WIDTH'(8);

   logic             w_accept;
   logic             w_is_opq;
   logic             w_illegal;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [1:0]       w_alufun;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_zf;
   logic             w_sf;
   logic             w_of;
   logic             w_cnd;
   logic [WIDTH-1:0] w_valE;

   logic             r_out_valid;
   logic [3:0]       r_out_icode;
   logic [WIDTH-1:0] r_out_valE;
   logic [WIDTH-1:0] r_out_valA;
   logic             r_out_cnd;
   logic             r_out_err;
   logic [2:0]       r_cc;

   // The single output slot can take a new result when empty or draining now
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_is_opq = (icode == I_OPQ);

   // Unknown icodes, OPq beyond xor and conditions beyond 'g' are illegal
   assign w_illegal = (icode > I_POPQ)
                   || (w_is_opq && (ifun > {2'b00, ALU_XOR}))
                   || (((icode == I_RRMOVQ) || (icode == I_JXX)) && (ifun > C_G));

   // ALU operand A/B selection by instruction class
   always_comb begin
      w_alu_a = '0;
      w_alu_b = '0;
      case (icode)
         I_RRMOVQ: w_alu_a = valA;
         I_OPQ: begin
            w_alu_a = valA;
            w_alu_b = valB;
         end
         I_IRMOVQ: w_alu_a = valC;
         I_RMMOVQ, I_MRMOVQ: begin
            w_alu_a = valC;
            w_alu_b = valB;
         end
         I_CALL, I_PUSHQ: begin
            w_alu_a = c_NEG8;
            w_alu_b = valB;
         end
         I_RET, I_POPQ: begin
            w_alu_a = c_POS8;
            w_alu_b = valB;
         end
         default: begin
            w_alu_a = '0;
            w_alu_b = '0;
         end
      endcase
   end

   assign w_alufun = w_is_opq ? ifun[1:0] : ALU_ADD;

   y86_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .aluA   (w_alu_a),
      .aluB   (w_alu_b),
      .alufun (w_alufun),
      .result (w_alu_res),
      .zf     (w_zf),
      .sf     (w_sf),
      .of     (w_of)
   );

   // Cnd uses the flags as they stand before this edge's CC update
   assign w_cnd  = !w_illegal && ((icode == I_RRMOVQ) || (icode == I_JXX))
                && cond_eval(ifun, r_cc);
   assign w_valE = w_illegal ? '0 : w_alu_res;

   // Output register slot and condition-code register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_icode <= 4'h0;
         r_out_valE  <= '0;
         r_out_valA  <= '0;
         r_out_cnd   <= 1'b0;
         r_out_err   <= 1'b0;
         r_cc        <= CC_RESET;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_icode <= icode;
            r_out_valE  <= w_valE;
            r_out_valA  <= valA;
            r_out_cnd   <= w_cnd;
            r_out_err   <= w_illegal;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept && w_is_opq && !w_illegal) begin
            r_cc[CC_ZF] <= w_zf;
            r_cc[CC_SF] <= w_sf;
            r_cc[CC_OF] <= w_of;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_icode = r_out_icode;
   assign out_valE  = r_out_valE;
   assign out_valA  = r_out_valA;
   assign out_cnd   = r_out_cnd;
   assign out_err   = r_out_err;
   assign cc        = r_cc;

endmodule : y86_execute_stage
`default_nettype wire

// File: doc/y86_execute_stage.md
Name: y86_execute_stage

Overview:
- Registered Execute stage of the Y86-64 SEQ datapath. Sits directly downstream of Decode, which supplies icode/ifun/valA/valB/valC.
- Selects ALU operands and computes valE with the word-wide ALU; the bitwise logic blocks live inside that ALU.
- Owns the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
- Results go through a one-entry valid/ready output register toward Memory/Write-back.

Parameters:
- WIDTH, 64, datapath width in bits.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  Decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- valA  in  WIDTH  decoded operand A.
- valB  in  WIDTH  decoded operand B.
- valC  in  WIDTH  immediate/displacement.
- out_valid  out  1  registered result available.
- out_ready  in  1  downstream accepts the result.
- out_icode  out  4  icode forwarded with the result.
- out_valE  out  WIDTH  ALU result.
- out_valA  out  WIDTH  valA forwarded (store data/return address).
- out_cnd  out  1  branch/move condition.
- out_err  out  1  illegal icode/ifun flag.
- cc  out  3  current {ZF,SF,OF}.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_icode=0, out_valE=0, out_valA=0, out_cnd=0, out_err=0, cc=CC_RESET. Deassertion is synchronised by the integrator, not by this block.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - accept = in_valid && in_ready.
  - On accept, all out_* load on the next edge and out_valid=1.
  - If out_valid && !out_ready, all out_* hold stable.
  - out_valid clears on out_ready && !accept.
  - Latency is 1 cycle. Back-to-back throughput is 1 per cycle when out_ready=1.
- ALU operand A:
  - valA for icode 2 (rrmovq/cmov) and 6 (OPq).
  - valC for 3, 4, 5.
  - -8 for 8 (call) and A (pushq).
  - +8 for 9 (ret) and B (popq).
  - 0 otherwise.
- ALU operand B:
  - valB for 4, 5, 6, 8, 9, A, B.
  - 0 for 2, 3 and all other icodes.
- ALU function: ifun for OPq. All other icodes use add.
- ALU ops: 0 add B+A; 1 sub B-A; 2 and; 3 xor. Arithmetic is mod 2^WIDTH.
- Flags:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF for add = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - OF for sub = (A[msb]!=B[msb]) && (R[msb]!=B[msb]).
  - OF for and/xor = 0.
- CC update: only on an accepted, legal OPq, at the same edge the result registers. No other icode touches CC.
- Cnd: evaluated from the CC value before that edge's update.
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&&!ZF.
  - out_cnd is meaningful for icode 2 and 7. It is 0 for all other icodes.
- Illegal encodings:
  - Conditions: icode>0xB; OPq with ifun>3; icode 2/7 with ifun>6.
  - Effect: out_err=1, out_valE=0, out_cnd=0, CC unchanged. The result still handshakes normally.
- halt (0) and nop (1): valE=0, out_err=0.
- Simultaneous events: accept coinciding with out_ready drains the old result and loads the new one in the same edge (out_valid stays 1).
- Reset mid-operation: the pending result is discarded and CC returns to CC_RESET immediately, without waiting for a clock.

Decomposition:
- Package y86_pkg:
  - icode constants: I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ.
  - ALU function codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR.
  - Condition codes: C_ALWAYS through C_G.
  - CC bit indices.
- Sub-module y86_alu: combinational; inputs aluA, aluB, alufun; outputs result, zf, sf, of.
- Operand select, Cnd evaluation, CC register and output register stay in y86_execute_stage.

Test Plan:
- Reset check: rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and cc=3'b100 before the next clk edge.
- OPq add overflow: valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, ifun=0 -> out_valE=0x8000_0000_0000_0000, cc=3'b011 one cycle later.
- Compare then branch: OPq sub with valA=valB=5 (cc becomes 3'b100), then jXX ifun=3 -> out_cnd=1; jXX ifun=4 -> out_cnd=0; the jXX does not change cc.
- Stack adjust: pushq with valB=0x100 -> out_valE=0xF8. popq with valB=0xF8 -> out_valE=0x100. cc unchanged.
- Backpressure: two back-to-back irmovq (valC=0x11, then 0x22) with out_ready=0 for 3 cycles -> in_ready=0; out_valE holds 0x11; 0x22 appears on the cycle after out_ready=1.
- Illegal encoding: icode=0xC -> out_err=1, out_valE=0, cc unchanged. OPq with ifun=5 -> out_err=1, cc unchanged.
